// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480@60 timing and helpers for the VGA raster timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACT  = 2'd0,
    PH_FP   = 2'd1,
    PH_SYNC = 2'd2,
    PH_BP   = 2'd3
  } phase_e;

  localparam int unsigned POS_W   = 11;
  localparam int unsigned POS_MAX = 2047;

  localparam int unsigned DEF_H_ACTIVE = 640;
  localparam int unsigned DEF_H_FP     = 16;
  localparam int unsigned DEF_H_SYNC   = 96;
  localparam int unsigned DEF_H_BP     = 48;
  localparam int unsigned DEF_V_ACTIVE = 480;
  localparam int unsigned DEF_V_FP     = 10;
  localparam int unsigned DEF_V_SYNC   = 2;
  localparam int unsigned DEF_V_BP     = 33;

  // Total period of one axis (pixels per line or lines per frame).
  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: pixel strobe in, coordinates/flags/sync out.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic             pix_en;
  logic [POS_W-1:0] pix_x;
  logic [POS_W-1:0] pix_y;
  logic             pix_active;
  logic             pix_vblank;
  logic             vga_hs;
  logic             vga_vs;
  logic             line_start;
  logic             frame_start;

  modport master (
    input  pix_en,
    output pix_x, pix_y, pix_active, pix_vblank, vga_hs, vga_vs, line_start, frame_start
  );

  modport slave (
    output pix_en,
    input  pix_x, pix_y, pix_active, pix_vblank, vga_hs, vga_vs, line_start, frame_start
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: phase FSM with down-counter, position counter and next-pixel decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  output logic [POS_W-1:0] pos_nxt_c,
  output logic             active_nxt_c,
  output logic             sync_nxt_c,
  output logic             wrap_c
);

  localparam int unsigned TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_zero_phase
    $error("vga_axis_counter: every phase length must be at least 1");
  end
  if (TOTAL > POS_MAX) begin : g_too_long
    $error("vga_axis_counter: axis total exceeds 2047");
  end

  phase_e           phase_q, phase_d;
  logic [POS_W-1:0] cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;

  function automatic logic [POS_W-1:0] phase_len(input phase_e ph);
    case (ph)
      PH_ACT:  return POS_W'(ACTIVE);
      PH_FP:   return POS_W'(FP);
      PH_SYNC: return POS_W'(SYNC);
      default: return POS_W'(BP);
    endcase
  endfunction

  // State register: phase, remaining length of phase, position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PH_ACT;
      cnt_q   <= POS_W'(ACTIVE);
      pos_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
    end
  end

  // Next state and decode of the pixel that the next enabled edge will present.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    wrap_c  = (phase_q == PH_BP) && (cnt_q == POS_W'(1));
    if (step) begin
      pos_d = wrap_c ? '0 : pos_q + POS_W'(1);
      if (cnt_q == POS_W'(1)) begin
        case (phase_q)
          PH_ACT:  phase_d = PH_FP;
          PH_FP:   phase_d = PH_SYNC;
          PH_SYNC: phase_d = PH_BP;
          default: phase_d = PH_ACT;
        endcase
        cnt_d = phase_len(phase_d);
      end else begin
        cnt_d = cnt_q - POS_W'(1);
      end
    end
    pos_nxt_c    = pos_d;
    active_nxt_c = (phase_d == PH_ACT);
    sync_nxt_c   = (phase_d == PH_SYNC);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: priming, axis chaining and registered pixel/sync outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0
) (
  input logic             clk,
  input logic             rst,
  vga_timing_gen_if.master bus
);

  logic             primed_q;
  logic             h_step_c, v_step_c;
  logic [POS_W-1:0] h_pos_nxt_c, v_pos_nxt_c;
  logic             h_act_nxt_c, v_act_nxt_c;
  logic             h_sync_nxt_c, v_sync_nxt_c;
  logic             h_wrap_c, v_wrap_c;

  // The priming edge presents (0,0) without moving either axis.
  assign h_step_c = bus.pix_en && primed_q;
  assign v_step_c = h_step_c && h_wrap_c;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk          (clk),
    .rst          (rst),
    .step         (h_step_c),
    .pos_nxt_c    (h_pos_nxt_c),
    .active_nxt_c (h_act_nxt_c),
    .sync_nxt_c   (h_sync_nxt_c),
    .wrap_c       (h_wrap_c)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk          (clk),
    .rst          (rst),
    .step         (v_step_c),
    .pos_nxt_c    (v_pos_nxt_c),
    .active_nxt_c (v_act_nxt_c),
    .sync_nxt_c   (v_sync_nxt_c),
    .wrap_c       (v_wrap_c)
  );

  // All outputs load together from the decode of the pixel being presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed_q        <= 1'b0;
      bus.pix_x       <= '0;
      bus.pix_y       <= '0;
      bus.pix_active  <= 1'b0;
      bus.pix_vblank  <= 1'b0;
      bus.vga_hs      <= !HS_POL;
      bus.vga_vs      <= !VS_POL;
      bus.line_start  <= 1'b0;
      bus.frame_start <= 1'b0;
    end else if (bus.pix_en) begin
      primed_q        <= 1'b1;
      bus.pix_x       <= h_pos_nxt_c;
      bus.pix_y       <= v_pos_nxt_c;
      bus.pix_active  <= h_act_nxt_c && v_act_nxt_c;
      bus.pix_vblank  <= !v_act_nxt_c;
      bus.vga_hs      <= h_sync_nxt_c ? HS_POL : !HS_POL;
      bus.vga_vs      <= v_sync_nxt_c ? VS_POL : !VS_POL;
      bus.line_start  <= !primed_q || h_wrap_c;
      bus.frame_start <= !primed_q || (h_wrap_c && v_wrap_c);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: three modes driven by a shared pixel strobe, checked against an arithmetic raster model.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic en;

  always #5 clk = ~clk;

  vga_timing_gen_if bus_def ();
  vga_timing_gen_if bus_tall ();
  vga_timing_gen_if bus_small ();

  assign bus_def.pix_en   = en;
  assign bus_tall.pix_en  = en;
  assign bus_small.pix_en = en;

  vga_timing_gen u_def (.clk(clk), .rst(rst), .bus(bus_def));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2)
  ) u_tall (.clk(clk), .rst(rst), .bus(bus_tall));

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) u_small (.clk(clk), .rst(rst), .bus(bus_small));

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } mode_t;

  typedef struct {
    logic [10:0] x, y;
    logic act, vbl, hs, vs, ls, fs;
  } exp_t;

  mode_t modes[3];
  bit    primed[3];
  int    n_adv[3];
  int    errors = 0;
  int    checks = 0;

  // Reference: a primed raster shows pixel number n_adv in row-major scan order.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        primed[i] <= 1'b0;
        n_adv[i]  <= 0;
      end else if (en) begin
        if (primed[i]) n_adv[i] <= n_adv[i] + 1;
        else primed[i] <= 1'b1;
      end
    end
  end

  function automatic exp_t expected(input mode_t m, input bit pr, input int n);
    exp_t e;
    int ht, vt, x, y;
    ht = m.ha + m.hf + m.hs + m.hb;
    vt = m.va + m.vf + m.vs + m.vb;
    if (!pr) begin
      e.x = '0; e.y = '0; e.act = 1'b0; e.vbl = 1'b0;
      e.hs = !m.hp; e.vs = !m.vp; e.ls = 1'b0; e.fs = 1'b0;
      return e;
    end
    x = n % ht;
    y = (n / ht) % vt;
    e.x   = 11'(x);
    e.y   = 11'(y);
    e.act = (x < m.ha) && (y < m.va);
    e.vbl = (y >= m.va);
    e.hs  = (x >= m.ha + m.hf && x < m.ha + m.hf + m.hs) ? m.hp : !m.hp;
    e.vs  = (y >= m.va + m.vf && y < m.va + m.vf + m.vs) ? m.vp : !m.vp;
    e.ls  = (x == 0);
    e.fs  = (x == 0) && (y == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string name, input exp_t e, input logic [10:0] x, input logic [10:0] y,
                         input logic a, input logic vb, input logic hs, input logic vs,
                         input logic ls, input logic fs);
    chk({name, ".x"},   32'(x),  32'(e.x));
    chk({name, ".y"},   32'(y),  32'(e.y));
    chk({name, ".act"}, 32'(a),  32'(e.act));
    chk({name, ".vbl"}, 32'(vb), 32'(e.vbl));
    chk({name, ".hs"},  32'(hs), 32'(e.hs));
    chk({name, ".vs"},  32'(vs), 32'(e.vs));
    chk({name, ".ls"},  32'(ls), 32'(e.ls));
    chk({name, ".fs"},  32'(fs), 32'(e.fs));
  endtask

  task automatic check_all();
    chk_bus("def", expected(modes[0], primed[0], n_adv[0]), bus_def.pix_x, bus_def.pix_y,
            bus_def.pix_active, bus_def.pix_vblank, bus_def.vga_hs, bus_def.vga_vs,
            bus_def.line_start, bus_def.frame_start);
    chk_bus("tall", expected(modes[1], primed[1], n_adv[1]), bus_tall.pix_x, bus_tall.pix_y,
            bus_tall.pix_active, bus_tall.pix_vblank, bus_tall.vga_hs, bus_tall.vga_vs,
            bus_tall.line_start, bus_tall.frame_start);
    chk_bus("small", expected(modes[2], primed[2], n_adv[2]), bus_small.pix_x, bus_small.pix_y,
            bus_small.pix_active, bus_small.pix_vblank, bus_small.vga_hs, bus_small.vga_vs,
            bus_small.line_start, bus_small.frame_start);
  endtask

  // One clock with the given strobe; outputs sampled on the falling edge.
  task automatic cyc(input logic e);
    en = e;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  int hs_cnt, hs_first, hs_last;
  int vbl_x, vbl_y, tall_vs_cnt, wrap_px, wrap_py, prev_tx, prev_ty;
  bit found, prev_vbl, sm_done, reached;
  int sm_first, sm_period, sm_hs, sm_vs;
  int hold_viol;
  logic [10:0] px, py;
  logic e_r;

  initial begin
    modes[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    modes[1] = '{8, 2, 3, 2, 480, 10, 2, 33, 1'b0, 1'b0};
    modes[2] = '{4, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b1};
    rst = 1'b1;
    en  = 1'b1;

    // Reset held with the strobe active.
    repeat (3) cyc(1'b1);
    chk("rst.def.hs",   32'(bus_def.vga_hs),     32'(1));
    chk("rst.def.act",  32'(bus_def.pix_active), 32'(0));
    chk("rst.small.hs", 32'(bus_small.vga_hs),   32'(0));

    // Priming edge then first advance.
    rst = 1'b0;
    cyc(1'b1);
    chk("prime.x",  32'(bus_def.pix_x),       32'(0));
    chk("prime.y",  32'(bus_def.pix_y),       32'(0));
    chk("prime.act", 32'(bus_def.pix_active), 32'(1));
    chk("prime.ls", 32'(bus_def.line_start),  32'(1));
    chk("prime.fs", 32'(bus_def.frame_start), 32'(1));
    cyc(1'b1);
    chk("adv1.x",  32'(bus_def.pix_x),       32'(1));
    chk("adv1.fs", 32'(bus_def.frame_start), 32'(0));

    // Rest of line 0 on the default mode.
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    for (int k = 0; k < 799; k++) begin
      cyc(1'b1);
      if (bus_def.pix_y == 11'd0 && bus_def.vga_hs == 1'b0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(bus_def.pix_x);
        hs_last = int'(bus_def.pix_x);
      end
    end
    chk("line.hs_cnt",   32'(hs_cnt),   32'(96));
    chk("line.hs_first", 32'(hs_first), 32'(656));
    chk("line.hs_last",  32'(hs_last),  32'(751));
    chk("line.wrap_x",   32'(bus_def.pix_x),      32'(0));
    chk("line.wrap_y",   32'(bus_def.pix_y),      32'(1));
    chk("line.wrap_ls",  32'(bus_def.line_start), 32'(1));

    // Full frame of the tall mode (default vertical timing); small mode period alongside.
    found = 1'b0; prev_vbl = bus_tall.pix_vblank;
    prev_tx = int'(bus_tall.pix_x); prev_ty = int'(bus_tall.pix_y);
    vbl_x = -1; vbl_y = -1; tall_vs_cnt = 0; wrap_px = -1; wrap_py = -1;
    sm_done = 1'b0; sm_first = -1; sm_period = 0; sm_hs = 0; sm_vs = 0;
    for (int k = 0; k < 8000 && !found; k++) begin
      cyc(1'b1);
      if (bus_tall.pix_vblank && !prev_vbl) begin
        vbl_x = int'(bus_tall.pix_x);
        vbl_y = int'(bus_tall.pix_y);
      end
      if (bus_tall.vga_vs == 1'b0) tall_vs_cnt++;
      if (bus_tall.frame_start) begin
        found = 1'b1;
        wrap_px = prev_tx;
        wrap_py = prev_ty;
      end
      prev_vbl = bus_tall.pix_vblank;
      prev_tx = int'(bus_tall.pix_x);
      prev_ty = int'(bus_tall.pix_y);
      if (!sm_done && bus_small.frame_start) begin
        if (sm_first >= 0) begin
          sm_period = k - sm_first;
          sm_done = 1'b1;
        end else begin
          sm_first = k;
        end
      end
      if (sm_first >= 0 && !sm_done) begin
        sm_hs += int'(bus_small.vga_hs);
        sm_vs += int'(bus_small.vga_vs);
      end
    end
    chk("frame.found",   32'(found),       32'(1));
    chk("frame.vbl_x",   32'(vbl_x),       32'(0));
    chk("frame.vbl_y",   32'(vbl_y),       32'(480));
    chk("frame.vs_cnt",  32'(tall_vs_cnt), 32'(30));
    chk("frame.wrap_px", 32'(wrap_px),     32'(14));
    chk("frame.wrap_py", 32'(wrap_py),     32'(524));
    chk("small.period",  32'(sm_period),   32'(42));
    chk("small.hs_cnt",  32'(sm_hs),       32'(6));
    chk("small.vs_cnt",  32'(sm_vs),       32'(7));

    // Random 1-in-3 strobe; outputs must hold on disabled edges.
    hold_viol = 0;
    for (int k = 0; k < 3000; k++) begin
      px = bus_def.pix_x;
      py = bus_def.pix_y;
      e_r = ($urandom_range(0, 2) == 0);
      cyc(e_r);
      if (!e_r && (bus_def.pix_x != px || bus_def.pix_y != py)) hold_viol++;
    end
    chk("rand.hold", 32'(hold_viol), 32'(0));

    // Asynchronous reset mid-line, away from any clock edge.
    reached = 1'b0;
    for (int k = 0; k < 900 && !reached; k++) begin
      cyc(1'b1);
      if (bus_def.pix_x == 11'd300) reached = 1'b1;
    end
    chk("mid.reached", 32'(reached), 32'(1));
    #2 rst = 1'b1;
    #1;
    chk("mid.x",  32'(bus_def.pix_x),      32'(0));
    chk("mid.y",  32'(bus_def.pix_y),      32'(0));
    chk("mid.hs", 32'(bus_def.vga_hs),     32'(1));
    chk("mid.act", 32'(bus_def.pix_active), 32'(0));
    check_all();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1);
    chk("resume.x",  32'(bus_def.pix_x),       32'(0));
    chk("resume.fs", 32'(bus_def.frame_start), 32'(1));
    cyc(1'b1);
    chk("resume.x1", 32'(bus_def.pix_x), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
